reg_write_arbiter: RTL and testbench

- Round-robin write arbiter and sequencer for the shared N-bit enable-loaded register (the 64-bit reg with CLK/R/E/data).
- Up to NREQ requesters post write requests. The arbiter selects one, captures its data, and pulses the register enable for exactly one cycle.
- It then returns a one-cycle ack to the winner once the register holds the new value.
- It sits between the requesting datapath blocks and the register's E/data inputs.

---
 rtl/reg_write_arbiter_pkg.sv | 25 ++
 rtl/reg_write_arbiter_if.sv | 36 +++
 rtl/reg_write_arbiter_rr_priority_pick.sv | 37 +++
 rtl/reg_write_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter_pkg
// Description : Shared types and constants for the register write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_write_arbiter_pkg;

    // Width of the completed-write counter.
    localparam int c_wr_cnt_w = 16;

    // Sequencer states: grant search, single-cycle enable, single-cycle ack.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Grant-id width for a given requester count.
    function automatic int calc_idw(input int nreq);
        return $clog2(nreq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter_if
// Description : Requester/register-side bus of the register write arbiter.
//               master = requesting datapath side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int N    = 64,
    parameter int NREQ = 4,
    parameter int IDW  = calc_idw(NREQ)
) ();

    logic [NREQ-1:0]       req;
    logic [NREQ*N-1:0]     data_in;
    logic                  reg_e;
    logic [N-1:0]          reg_data;
    logic [NREQ-1:0]       ack;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;
    logic [c_wr_cnt_w-1:0] wr_count;

    modport master (
        output req, data_in,
        input  reg_e, reg_data, ack, gnt_id, busy, wr_count
    );

    modport slave (
        input  req, data_in,
        output reg_e, reg_data, ack, gnt_id, busy, wr_count
    );

endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational rotating-priority search. Returns the first
//               set request found starting at ptr and wrapping modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  winner
);

    // Walk from the farthest offset back to ptr so the closest hit is written last.
    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx[IDW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin write arbiter/sequencer for a shared enable-loaded
//               register. Grants one requester, pulses reg_e for one cycle,
//               then returns a one-cycle ack. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N    = 64,
    parameter int NREQ = 4,
    parameter int IDW  = calc_idw(NREQ)
) (
    input  logic               CLK,
    input  logic               R,
    reg_write_arbiter_if.slave bus
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;

    logic                  r_reg_e;
    logic [N-1:0]          r_reg_data;
    logic [NREQ-1:0]       r_ack;
    logic [IDW-1:0]        r_gnt_id;
    logic                  r_busy;
    logic [c_wr_cnt_w-1:0] r_wr_count;
    logic [IDW-1:0]        r_ptr;

    logic                  w_reg_e_nxt;
    logic [N-1:0]          w_reg_data_nxt;
    logic [NREQ-1:0]       w_ack_nxt;
    logic [IDW-1:0]        w_gnt_nxt;
    logic                  w_busy_nxt;
    logic [c_wr_cnt_w-1:0] w_cnt_nxt;
    logic [IDW-1:0]        w_ptr_nxt;

    logic                  w_valid;
    logic [IDW-1:0]        w_win;
    logic [N-1:0]          w_slices [NREQ];

    // Unpack the per-requester data lanes so the winner can index them directly.
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_slices[g] = bus.data_in[g*N +: N];
    end

    rr_priority_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .valid  (w_valid),
        .winner (w_win)
    );

    // Next-state and next-output decode; requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt    = r_state;
        w_reg_e_nxt    = 1'b0;
        w_reg_data_nxt = r_reg_data;
        w_ack_nxt      = '0;
        w_gnt_nxt      = r_gnt_id;
        w_busy_nxt     = r_busy;
        w_cnt_nxt      = r_wr_count;
        w_ptr_nxt      = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_gnt_nxt      = w_win;
                    w_reg_data_nxt = w_slices[w_win];
                    w_reg_e_nxt    = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = WRITE;
                end
            end
            WRITE: begin
                w_ack_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt_id;
                w_state_nxt = ACK;
            end
            ACK: begin
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;
                w_cnt_nxt   = r_wr_count + c_wr_cnt_w'(1);
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any write in progress.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and pointer registers; reset clears reg_e without waiting for a clock.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_reg_e    <= 1'b0;
            r_reg_data <= '0;
            r_ack      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_wr_count <= '0;
            r_ptr      <= '0;
        end else begin
            r_reg_e    <= w_reg_e_nxt;
            r_reg_data <= w_reg_data_nxt;
            r_ack      <= w_ack_nxt;
            r_gnt_id   <= w_gnt_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_count <= w_cnt_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    assign bus.reg_e    = r_reg_e;
    assign bus.reg_data = r_reg_data;
    assign bus.ack      = r_ack;
    assign bus.gnt_id   = r_gnt_id;
    assign bus.busy     = r_busy;
    assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter with a
//               transaction-level reference model and a model of the
//               controlled register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    localparam int N    = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_ptr;
    logic [15:0]     m_cnt;
    logic [N-1:0]    m_regdata;
    logic [NREQ-1:0] pend;
    logic [N-1:0]    dat [NREQ];

    logic [N-1:0]    reg_q;
    int              obs_w;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

    reg_write_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .CLK (clk),
        .R   (rst_n),
        .bus (bus)
    );

    // The controlled register: loads reg_data whenever reg_e is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_q <= '0;
        else if (bus.reg_e) reg_q <= bus.reg_data;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Winner = pending requester at the smallest rotational distance from ptr.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) begin
                int d = (i - p + NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) bus.data_in[i*N +: N] = dat[i];
        bus.req = pend;
    endtask

    // Called at a negedge with the DUT idle and pend != 0 already driven.
    task automatic txn(input bit late, input bit rearm, output int w_seen);
        int           w;
        logic [N-1:0] d;
        w = model_pick(pend, m_ptr);
        d = dat[w];
        @(negedge clk);
        chk("wr_reg_e", {63'd0, bus.reg_e}, 64'd1);
        chk("wr_gnt_id", {62'd0, bus.gnt_id}, 64'(w));
        chk("wr_reg_data", bus.reg_data, d);
        chk("wr_busy", {63'd0, bus.busy}, 64'd1);
        chk("wr_ack", {60'd0, bus.ack}, 64'd0);
        w_seen = int'(bus.gnt_id);
        if (late) begin
            dat[w]  = '1;
            pend[w] = 1'b0;
            drive();
        end
        @(negedge clk);
        chk("ack_onehot", {60'd0, bus.ack}, 64'd1 << w);
        chk("ack_reg_e", {63'd0, bus.reg_e}, 64'd0);
        chk("ack_reg_q", reg_q, d);
        pend[w] = 1'b0;
        drive();
        m_ptr     = (w + 1) % NREQ;
        m_cnt     = m_cnt + 16'd1;
        m_regdata = d;
        @(negedge clk);
        chk("idle_busy", {63'd0, bus.busy}, 64'd0);
        chk("idle_ack", {60'd0, bus.ack}, 64'd0);
        chk("idle_wr_count", {48'd0, bus.wr_count}, {48'd0, m_cnt});
        chk("idle_reg_data", bus.reg_data, m_regdata);
        if (rearm) begin
            pend[w] = 1'b1;
            drive();
        end
    endtask

    initial begin
        logic [NREQ-1:0] nr;
        m_ptr     = 0;
        m_cnt     = '0;
        m_regdata = '0;
        pend      = '0;
        for (int i = 0; i < NREQ; i++) dat[i] = '0;
        drive();

        // Power-on reset
        @(negedge clk);
        chk("rst_reg_e", {63'd0, bus.reg_e}, 64'd0);
        chk("rst_reg_data", bus.reg_data, 64'd0);
        chk("rst_ack", {60'd0, bus.ack}, 64'd0);
        chk("rst_gnt_id", {62'd0, bus.gnt_id}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_wr_count", {48'd0, bus.wr_count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request on id 1
        dat[1]  = 64'h0123_4567_89AB_CDEF;
        pend[1] = 1'b1;
        drive();
        txn(1'b0, 1'b0, obs_w);
        chk("single_wr_count", {48'd0, bus.wr_count}, 64'd1);

        // Pointer rotation: grant 2, then 0101 -> 0 then 2
        dat[2]  = 64'h2222_0000_2222_0000;
        pend[2] = 1'b1;
        drive();
        txn(1'b0, 1'b0, obs_w);
        dat[0] = 64'h0000_AAAA_0000_AAAA;
        dat[2] = 64'h2222_BBBB_2222_BBBB;
        pend   = 4'b0101;
        drive();
        txn(1'b0, 1'b0, obs_w);
        chk("rot_first", 64'(obs_w), 64'd0);
        txn(1'b0, 1'b0, obs_w);
        chk("rot_second", 64'(obs_w), 64'd2);

        // Reset mid-WRITE with requester 2 granted
        dat[2]  = 64'hDEAD_BEEF_0000_0001;
        pend    = 4'b0100;
        drive();
        @(negedge clk);
        chk("pre_rst_reg_e", {63'd0, bus.reg_e}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_reg_e", {63'd0, bus.reg_e}, 64'd0);
        chk("arst_reg_data", bus.reg_data, 64'd0);
        chk("arst_gnt_id", {62'd0, bus.gnt_id}, 64'd0);
        chk("arst_busy", {63'd0, bus.busy}, 64'd0);
        chk("arst_wr_count", {48'd0, bus.wr_count}, 64'd0);
        m_ptr     = 0;
        m_cnt     = '0;
        m_regdata = '0;
        for (int i = 0; i < NREQ; i++) dat[i] = 64'(i + 1) * 64'h1111_0000_0000_1111;
        pend = 4'b1111;
        drive();
        @(negedge clk);
        chk("arst_ack", {60'd0, bus.ack}, 64'd0);
        rst_n = 1'b1;

        // Full contention: rotation 0,1,2,3,0 starting from the reset pointer
        for (int k = 0; k < 5; k++) begin
            txn(1'b0, 1'b1, obs_w);
            chk("contention_order", 64'(obs_w), 64'(k % NREQ));
        end
        chk("contention_count", {48'd0, bus.wr_count}, 64'd5);
        pend = '0;
        drive();
        @(negedge clk);

        // Late data/request change after grant to 3
        dat[3]  = 64'h3333_CAFE_3333_CAFE;
        pend[3] = 1'b1;
        drive();
        txn(1'b1, 1'b0, obs_w);
        chk("late_reg_q", reg_q, 64'h3333_CAFE_3333_CAFE);

        // Randomized traffic; pending requesters keep their data until acked
        for (int it = 0; it < 40; it++) begin
            nr = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (nr[i] && !pend[i]) begin
                    dat[i]  = {$urandom, $urandom};
                    pend[i] = 1'b1;
                end
            end
            drive();
            if (pend == '0) begin
                @(negedge clk);
                chk("rnd_idle_reg_e", {63'd0, bus.reg_e}, 64'd0);
                chk("rnd_idle_reg_data", bus.reg_data, m_regdata);
            end else begin
                txn(1'b0, 1'b0, obs_w);
            end
        end
        pend = '0;
        drive();
        @(negedge clk);

        // Counter wrap: preload near the top, then two writes
        force dut.r_wr_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_wr_count;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        chk("wrap_preload", {48'd0, bus.wr_count}, 64'h0000_0000_0000_FFFE);
        dat[0]  = 64'h0F0F_0F0F_0F0F_0F0F;
        pend[0] = 1'b1;
        drive();
        txn(1'b0, 1'b0, obs_w);
        chk("wrap_ffff", {48'd0, bus.wr_count}, 64'h0000_0000_0000_FFFF);
        dat[1]  = 64'hF0F0_F0F0_F0F0_F0F0;
        pend[1] = 1'b1;
        drive();
        txn(1'b0, 1'b0, obs_w);
        chk("wrap_zero", {48'd0, bus.wr_count}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
